// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: controller state encoding, destination and
// trusted-source byte values, and the destination decode used by the controller.
package router_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] GET_SOURCE   = 3'd0;
    localparam logic [STATE_W-1:0] GET_DEST     = 3'd1;
    localparam logic [STATE_W-1:0] STORE_HEADER = 3'd2;
    localparam logic [STATE_W-1:0] GET_SIZE     = 3'd3;
    localparam logic [STATE_W-1:0] LOAD_DATA    = 3'd4;
    localparam logic [STATE_W-1:0] GET_CRC      = 3'd5;
    localparam logic [STATE_W-1:0] CHK_CRC      = 3'd6;
    localparam logic [STATE_W-1:0] FULL_WAIT    = 3'd7;

    localparam logic [7:0] DEST0 = 8'h01;
    localparam logic [7:0] DEST1 = 8'h02;
    localparam logic [7:0] DEST2 = 8'h03;

    localparam logic [7:0] TS1 = 8'h81;
    localparam logic [7:0] TS2 = 8'h82;
    localparam logic [7:0] TS3 = 8'h83;

    typedef struct packed {
        logic       hit;
        logic [1:0] sel;
    } dest_dec_t;

    // Unknown destinations fall back to FIFO 0 with hit cleared so the caller can drop.
    function automatic dest_dec_t decode_dest(
        input logic [7:0] dest,
        input logic [7:0] d0,
        input logic [7:0] d1,
        input logic [7:0] d2
    );
        dest_dec_t r;
        r.hit = 1'b1;
        if (dest == d1) begin
            r.sel = 2'd1;
        end else if (dest == d2) begin
            r.sel = 2'd2;
        end else begin
            r.sel = 2'd0;
            r.hit = (dest == d0);
        end
        return r;
    endfunction

endpackage

// File: rtl/router_sat_cnt.sv
// Saturating up-counter used for the good / error / dropped packet statistics.
module router_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);
    import router_pkg::*;

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router controller FSM: sequences packet field capture, steers writes to one of three
// output FIFOs, throttles the source on a full FIFO and counts packet outcomes.
module router_fsm_ctrl #(
    parameter logic [7:0] DEST0 = router_pkg::DEST0,
    parameter logic [7:0] DEST1 = router_pkg::DEST1,
    parameter logic [7:0] DEST2 = router_pkg::DEST2,
    parameter int         CNT_W = 8
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             packet_valid_i,
    input  logic [2:0]       fifo_full,
    input  logic             trusted_source,
    input  logic [7:0]       destination,
    input  logic [2:0]       dsize,
    input  logic             crc_checked,
    input  logic             err,
    output logic             get_source,
    output logic             get_dest,
    output logic             store_header,
    output logic             get_size,
    output logic             load_data,
    output logic             get_crc,
    output logic             full_state,
    output logic             sel_fifo_full,
    output logic [2:0]       write_enb,
    output logic             packet_send,
    output logic             busy,
    output logic             pkt_done,
    output logic             pkt_err,
    output logic             pkt_drop,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    import router_pkg::*;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_state_next;
    logic [STATE_W-1:0] r_ret_state;
    logic [STATE_W-1:0] r_ret_state_next;
    logic [1:0]         r_dest_sel;
    logic [1:0]         r_dest_sel_next;
    logic               r_drop;
    logic               r_drop_next;
    logic [2:0]         r_count;
    logic [2:0]         r_count_next;

    dest_dec_t          w_dec;
    logic               w_dec_drop;
    logic               w_dest_latched;
    logic               w_acc;
    logic               w_wr_cycle;
    logic               w_wr_drop;
    logic [1:0]         w_wr_sel;
    logic               w_wr_en;
    logic               w_eop;
    logic               w_crc_bad;

    assign w_dec      = decode_dest(destination, DEST0, DEST1, DEST2);
    assign w_dec_drop = !trusted_source || !w_dec.hit;

    // The destination register only means something once GET_DEST has accepted a byte.
    assign w_dest_latched = (r_state != GET_SOURCE) && (r_state != GET_DEST);
    assign sel_fifo_full  = w_dest_latched && fifo_full[r_dest_sel];

    always_comb begin
        packet_send = 1'b0;
        case (r_state)
            GET_SOURCE, GET_DEST, GET_SIZE, LOAD_DATA, GET_CRC: packet_send = !sel_fifo_full;
            default:                                            packet_send = 1'b0;
        endcase
    end

    assign w_acc = packet_valid_i && packet_send;

    assign get_source   = (r_state == GET_SOURCE);
    assign get_dest     = (r_state == GET_DEST);
    assign store_header = (r_state == STORE_HEADER);
    assign get_size     = (r_state == GET_SIZE);
    assign load_data    = (r_state == LOAD_DATA);
    assign get_crc      = (r_state == GET_CRC);
    assign full_state   = (r_state == FULL_WAIT);
    assign busy         = (r_state != GET_SOURCE);

    always_comb begin
        r_state_next     = r_state;
        r_ret_state_next = r_ret_state;
        r_dest_sel_next  = r_dest_sel;
        r_drop_next      = r_drop;
        r_count_next     = r_count;
        case (r_state)
            GET_SOURCE: begin
                if (w_acc) begin
                    r_state_next = GET_DEST;
                end
            end
            GET_DEST: begin
                if (w_acc) begin
                    r_dest_sel_next = w_dec.sel;
                    r_drop_next     = w_dec_drop;
                    r_state_next    = STORE_HEADER;
                end
            end
            STORE_HEADER: begin
                if (!sel_fifo_full) begin
                    r_state_next = GET_SIZE;
                end
            end
            GET_SIZE: begin
                if (sel_fifo_full && !r_drop) begin
                    r_ret_state_next = GET_SIZE;
                    r_state_next     = FULL_WAIT;
                end else if (w_acc) begin
                    r_count_next = dsize;
                    r_state_next = (dsize != 3'd0) ? LOAD_DATA : GET_CRC;
                end
            end
            LOAD_DATA: begin
                if (sel_fifo_full && !r_drop) begin
                    r_ret_state_next = LOAD_DATA;
                    r_state_next     = FULL_WAIT;
                end else if (w_acc) begin
                    r_count_next = r_count - 3'd1;
                    if (r_count <= 3'd1) begin
                        r_state_next = GET_CRC;
                    end
                end
            end
            GET_CRC: begin
                if (sel_fifo_full && !r_drop) begin
                    r_ret_state_next = GET_CRC;
                    r_state_next     = FULL_WAIT;
                end else if (w_acc) begin
                    r_state_next = CHK_CRC;
                end
            end
            CHK_CRC: begin
                r_state_next = GET_SOURCE;
            end
            FULL_WAIT: begin
                if (!fifo_full[r_dest_sel]) begin
                    r_state_next = r_ret_state;
                end
            end
            default: begin
                r_state_next = GET_SOURCE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_state     <= GET_SOURCE;
            r_ret_state <= GET_SOURCE;
            r_dest_sel  <= 2'd0;
            r_drop      <= 1'b0;
            r_count     <= 3'd0;
        end else begin
            r_state     <= r_state_next;
            r_ret_state <= r_ret_state_next;
            r_dest_sel  <= r_dest_sel_next;
            r_drop      <= r_drop_next;
            r_count     <= r_count_next;
        end
    end

    // In GET_DEST the destination is still on the inputs, so steer from the live decode.
    assign w_wr_sel  = (r_state == GET_DEST) ? w_dec.sel  : r_dest_sel;
    assign w_wr_drop = (r_state == GET_DEST) ? w_dec_drop : r_drop;

    always_comb begin
        w_wr_cycle = 1'b0;
        case (r_state)
            GET_DEST, GET_SIZE, LOAD_DATA, GET_CRC: w_wr_cycle = w_acc;
            STORE_HEADER:                           w_wr_cycle = 1'b1;
            default:                                w_wr_cycle = 1'b0;
        endcase
    end

    assign w_wr_en = w_wr_cycle && !w_wr_drop && !sel_fifo_full;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_wr
            assign write_enb[gi] = w_wr_en && (w_wr_sel == gi[1:0]);
        end
    endgenerate

    assign w_eop     = (r_state == CHK_CRC);
    assign w_crc_bad = crc_checked && err;
    assign pkt_drop  = w_eop && r_drop;
    assign pkt_err   = w_eop && !r_drop && w_crc_bad;
    assign pkt_done  = w_eop && !r_drop && !w_crc_bad;

    router_sat_cnt #(.CNT_W(CNT_W)) u_good_cnt (
        .clk1  (clk1),
        .reset (reset),
        .inc   (pkt_done),
        .q     (good_cnt)
    );

    router_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk1  (clk1),
        .reset (reset),
        .inc   (pkt_err),
        .q     (err_cnt)
    );

    router_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk1  (clk1),
        .reset (reset),
        .inc   (pkt_drop),
        .q     (drop_cnt)
    );

endmodule
